// File: rtl/param_comb_stage_pkg.sv
// rtl/param_comb_stage_pkg.sv - shared types and defaults for the parameterised comb stage
package param_comb_stage_pkg;

   typedef enum logic {
      FILL,
      RUN
   } comb_state_t;

   localparam int DEFAULT_DATA_W    = 26;
   localparam int DEFAULT_MAX_DEPTH = 256;

endpackage

// File: rtl/param_comb_stage_ram.sv
// rtl/param_comb_stage_ram.sv - comb_delay_ram: circular delay storage, one write port, one synchronous read port
module comb_delay_ram #(
   parameter int  WIDTH = 26,
   parameter int  DEPTH = 256,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] rd_data_q;

   // Read and write share the edge, so a colliding read returns the pre-write word.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data_q <= mem[rd_addr];
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/param_comb_stage.sv
// rtl/param_comb_stage.sv - comb filter y[n] = x[n] - x[n-D] with runtime depth, bypass and fill tracking
module param_comb_stage
   import param_comb_stage_pkg::*;
#(
   parameter int  DATA_W    = DEFAULT_DATA_W,
   parameter int  MAX_DEPTH = DEFAULT_MAX_DEPTH,
   localparam int DW        = $clog2(MAX_DEPTH + 1)
) (
   input  logic                     SYS_CLK,
   input  logic                     RESET,
   input  logic                     CFG_LOAD,
   input  logic [DW-1:0]            CFG_DEPTH,
   input  logic                     CFG_BYPASS,
   input  logic                     IN_VALID,
   input  logic signed [DATA_W-1:0] DATAIN,
   output logic                     OUT_VALID,
   output logic signed [DATA_W:0]   DATAOUT,
   output logic                     PRIMED,
   output logic                     CFG_ERR
);

   localparam int AW = $clog2(MAX_DEPTH);
   localparam logic [DW-1:0] MAX_D     = DW'(MAX_DEPTH);
   localparam logic [AW-1:0] LAST_ADDR = AW'(MAX_DEPTH - 1);

   comb_state_t              state_q, state_d, cur_state;
   logic [DW-1:0]            depth_q, depth_d, cur_depth;
   logic [DW-1:0]            fill_q, fill_d, cur_fill;
   logic                     bypass_q, bypass_d, cur_bypass;
   logic [AW-1:0]            wr_ptr_q, wr_ptr_d, rd_addr;
   logic                     cfg_err_q, cfg_err_d;
   logic                     s1_valid_q, s1_valid_d;
   logic                     s1_mask_q, s1_mask_d;
   logic                     s1_bypass_q, s1_bypass_d;
   logic signed [DATA_W-1:0] s1_data_q, s1_data_d;
   logic                     out_valid_q, out_valid_d;
   logic signed [DATA_W:0]   dataout_q, dataout_d;
   logic signed [DATA_W-1:0] rd_data;
   logic signed [DATA_W:0]   x_ext, h_ext;
   logic [DW:0]              ptr_ext, dep_ext;
   logic                     load_ok;

   comb_delay_ram #(
      .WIDTH (DATA_W),
      .DEPTH (MAX_DEPTH)
   ) u_ram (
      .clk     (SYS_CLK),
      .wr_en   (IN_VALID),
      .wr_addr (wr_ptr_q),
      .wr_data (DATAIN),
      .rd_en   (IN_VALID),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   always_comb begin
      load_ok    = CFG_LOAD && (CFG_DEPTH != '0) && (CFG_DEPTH <= MAX_D);
      // A same-cycle sample already sees the freshly loaded configuration.
      cur_state  = load_ok ? FILL : state_q;
      cur_depth  = load_ok ? CFG_DEPTH : depth_q;
      cur_bypass = load_ok ? CFG_BYPASS : bypass_q;
      cur_fill   = load_ok ? '0 : fill_q;

      state_d     = cur_state;
      depth_d     = cur_depth;
      bypass_d    = cur_bypass;
      fill_d      = cur_fill;
      wr_ptr_d    = wr_ptr_q;
      cfg_err_d   = CFG_LOAD && !load_ok;
      s1_valid_d  = IN_VALID;
      s1_mask_d   = s1_mask_q;
      s1_bypass_d = s1_bypass_q;
      s1_data_d   = s1_data_q;

      if (IN_VALID) begin
         s1_mask_d   = (cur_state == FILL);
         s1_bypass_d = cur_bypass;
         s1_data_d   = DATAIN;
         wr_ptr_d    = (wr_ptr_q == LAST_ADDR) ? '0 : wr_ptr_q + 1'b1;
         if (cur_state == FILL) begin
            fill_d = cur_fill + 1'b1;
            if (fill_d == cur_depth) state_d = RUN;
         end
      end

      ptr_ext = (DW + 1)'(wr_ptr_q);
      dep_ext = {1'b0, cur_depth};
      rd_addr = (ptr_ext >= dep_ext) ? AW'(ptr_ext - dep_ext)
                                     : AW'(ptr_ext + (DW + 1)'(MAX_DEPTH) - dep_ext);

      // Both terms are sign-extended one bit, so the difference can never wrap.
      x_ext       = {s1_data_q[DATA_W-1], s1_data_q};
      h_ext       = s1_mask_q ? '0 : {rd_data[DATA_W-1], rd_data};
      out_valid_d = s1_valid_q;
      dataout_d   = dataout_q;
      if (s1_valid_q) dataout_d = s1_bypass_q ? x_ext : x_ext - h_ext;
   end

   always_ff @(posedge SYS_CLK or posedge RESET) begin
      if (RESET) begin
         state_q     <= FILL;
         depth_q     <= DW'(1);
         fill_q      <= '0;
         bypass_q    <= 1'b0;
         wr_ptr_q    <= '0;
         cfg_err_q   <= 1'b0;
         s1_valid_q  <= 1'b0;
         s1_mask_q   <= 1'b1;
         s1_bypass_q <= 1'b0;
         s1_data_q   <= '0;
         out_valid_q <= 1'b0;
         dataout_q   <= '0;
      end else begin
         state_q     <= state_d;
         depth_q     <= depth_d;
         fill_q      <= fill_d;
         bypass_q    <= bypass_d;
         wr_ptr_q    <= wr_ptr_d;
         cfg_err_q   <= cfg_err_d;
         s1_valid_q  <= s1_valid_d;
         s1_mask_q   <= s1_mask_d;
         s1_bypass_q <= s1_bypass_d;
         s1_data_q   <= s1_data_d;
         out_valid_q <= out_valid_d;
         dataout_q   <= dataout_d;
      end
   end

   assign OUT_VALID = out_valid_q;
   assign DATAOUT   = dataout_q;
   assign PRIMED    = (state_q == RUN);
   assign CFG_ERR   = cfg_err_q;

endmodule

// File: tb/tb_param_comb_stage.sv
// tb/tb_param_comb_stage.sv - randomized scoreboard bench for param_comb_stage
module tb_param_comb_stage;

   localparam int DATA_W    = 26;
   localparam int MAX_DEPTH = 256;
   localparam int DW        = $clog2(MAX_DEPTH + 1);

   logic                     SYS_CLK    = 1'b0;
   logic                     RESET      = 1'b0;
   logic                     CFG_LOAD   = 1'b0;
   logic [DW-1:0]            CFG_DEPTH  = '0;
   logic                     CFG_BYPASS = 1'b0;
   logic                     IN_VALID   = 1'b0;
   logic signed [DATA_W-1:0] DATAIN     = '0;
   logic                     OUT_VALID;
   logic signed [DATA_W:0]   DATAOUT;
   logic                     PRIMED;
   logic                     CFG_ERR;

   param_comb_stage #(
      .DATA_W    (DATA_W),
      .MAX_DEPTH (MAX_DEPTH)
   ) dut (
      .SYS_CLK    (SYS_CLK),
      .RESET      (RESET),
      .CFG_LOAD   (CFG_LOAD),
      .CFG_DEPTH  (CFG_DEPTH),
      .CFG_BYPASS (CFG_BYPASS),
      .IN_VALID   (IN_VALID),
      .DATAIN     (DATAIN),
      .OUT_VALID  (OUT_VALID),
      .DATAOUT    (DATAOUT),
      .PRIMED     (PRIMED),
      .CFG_ERR    (CFG_ERR)
   );

   always #5 SYS_CLK = ~SYS_CLK;

   int cyc = 0;
   always @(posedge SYS_CLK) cyc <= cyc + 1;

   typedef struct {
      longint val;
      int     due;
   } exp_t;

   exp_t   exp_q[$];
   longint hist[$];
   int     m_depth = 1;
   bit     m_byp   = 1'b0;
   int     m_fill  = 0;
   int     checks  = 0;
   int     errors  = 0;
   longint last_out = 0;

   function automatic void check(input string name, input longint got, input longint want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
      end
   endfunction

   always @(negedge SYS_CLK) begin
      if (OUT_VALID) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: got value %0d with no expected output (cycle %0d)",
                     longint'(DATAOUT), cyc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("dataout", longint'(DATAOUT), e.val);
            check("latency", cyc, e.due);
         end
         last_out = longint'(DATAOUT);
      end
   end

   task automatic drive(input bit ld, input int dep, input bit byp, input bit vld, input longint x);
      bit     ok;
      longint y;
      CFG_LOAD   = ld;
      CFG_DEPTH  = dep[DW-1:0];
      CFG_BYPASS = byp;
      IN_VALID   = vld;
      DATAIN     = x[DATA_W-1:0];
      ok = ld && (dep >= 1) && (dep <= MAX_DEPTH);
      if (ok) begin
         m_depth = dep;
         m_byp   = byp;
         m_fill  = 0;
      end
      if (vld) begin
         y = m_byp ? x : x - ((m_fill >= m_depth) ? hist[hist.size() - m_depth] : 64'sd0);
         exp_q.push_back('{y, cyc + 2});
         hist.push_back(x);
         m_fill++;
      end
      @(posedge SYS_CLK);
      #1;
      check("cfg_err", longint'(CFG_ERR), longint'(ld && !ok));
      check("primed", longint'(PRIMED), longint'(m_fill >= m_depth));
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 0, 1'b0, 1'b0, 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_dataout"}, longint'(DATAOUT), 0);
      check({tag, "_out_valid"}, longint'(OUT_VALID), 0);
      check({tag, "_primed"}, longint'(PRIMED), 0);
      check({tag, "_cfg_err"}, longint'(CFG_ERR), 0);
   endtask

   task automatic reset_model();
      exp_q.delete();
      hist.delete();
      m_depth = 1;
      m_byp   = 1'b0;
      m_fill  = 0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      logic signed [DATA_W-1:0] r;
      int                       sel;
      int                       dep;
      int                       gap_vld [7] = '{1, 0, 0, 1, 1, 0, 1};
      int                       gap_idx;

      #1 RESET = 1'b1;
      #1 check_reset_outputs("reset");
      repeat (2) @(posedge SYS_CLK);
      #1 RESET = 1'b0;
      reset_model();

      // D=4 ramp 1..10
      drive(1'b1, 4, 1'b0, 1'b0, 0);
      for (int i = 1; i <= 10; i++) drive(1'b0, 0, 1'b0, 1'b1, i);
      idle(3);

      // rejected loads keep D=4 and PRIMED
      drive(1'b1, 0, 1'b0, 1'b0, 0);
      drive(1'b1, 257, 1'b1, 1'b0, 0);
      for (int i = 1; i <= 6; i++) drive(1'b0, 0, 1'b0, 1'b1, i * 7);
      idle(3);

      // D=1 full-scale swing
      drive(1'b1, 1, 1'b0, 1'b0, 0);
      drive(1'b0, 0, 1'b0, 1'b1, -(64'sd1 <<< 25));
      drive(1'b0, 0, 1'b0, 1'b1, (64'sd1 <<< 25) - 1);
      idle(3);
      check("no_wrap", last_out, (64'sd1 <<< 26) - 1);

      // D=3 with valid gaps
      drive(1'b1, 3, 1'b0, 1'b0, 0);
      gap_idx = 5;
      for (int i = 0; i < 7; i++) begin
         if (gap_vld[i] != 0) begin
            drive(1'b0, 0, 1'b0, 1'b1, gap_idx);
            gap_idx++;
         end else begin
            drive(1'b0, 0, 1'b0, 1'b0, 0);
         end
      end
      idle(3);
      check("gap_last", last_out, 3);

      // D=MAX_DEPTH, pointer wrap and read/write collision
      drive(1'b1, MAX_DEPTH, 1'b0, 1'b0, 0);
      repeat (600) drive(1'b0, 0, 1'b0, 1'b1, 100);
      idle(3);
      check("deep_last", last_out, 0);

      // randomized mix of loads, bypass, gaps and data
      repeat (2500) begin
         bit ld;
         ld  = ($urandom % 40) == 0;
         sel = $urandom % 10;
         if (sel == 0)      dep = 0;
         else if (sel == 1) dep = 257 + ($urandom % 255);
         else if (sel == 2) dep = MAX_DEPTH;
         else if (sel == 3) dep = $urandom_range(1, MAX_DEPTH);
         else               dep = $urandom_range(1, 12);
         r = DATA_W'($urandom);
         drive(ld, dep, ($urandom % 4) == 0, ($urandom % 3) != 0, longint'(r));
      end
      idle(3);

      // bypass stream interrupted by reset
      drive(1'b1, 5, 1'b1, 1'b0, 0);
      for (int i = 0; i < 6; i++) begin
         r = DATA_W'($urandom);
         drive(1'b0, 0, 1'b0, 1'b1, longint'(r));
      end
      #2 RESET = 1'b1;
      #1 check_reset_outputs("midreset");
      reset_model();
      IN_VALID = 1'b0;
      CFG_LOAD = 1'b0;
      repeat (2) @(posedge SYS_CLK);
      #1 RESET = 1'b0;
      idle(6);

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d outputs still pending, expected 0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
